sub_serial: RTL and testbench
=============================

# sub_serial

Bit-serial subtractor computing `Diff = A - B - Bin` one bit per clock, LSB first, with a start/busy/done handshake. It is the inverse counterpart of the combinational 3-bit adder (`A`, `B`, `Cin` → `Sum`, `Cout`). It sits in the same arithmetic lab datapath, so the two can be chained for add-then-subtract round-trip checks. Results are registered and held until the next operation completes.

## Interface
- `WIDTH`, default 3: operand and result width in bits; legal range 2–16.
- `clk`  input  1: rising-edge clock.
- `rst_n`  input  1: synchronous, active-low reset.
- `start`  input  1: request a new operation; sampled only in IDLE.
- `A`  input  WIDTH: minuend; captured on the accepting edge.
- `B`  input  WIDTH: subtrahend; captured on the accepting edge.
- `Bin`  input  1: borrow-in; captured on the accepting edge.
- `busy`  output  1: high while bits are being processed (SHIFT).
- `done`  output  1: one-cycle pulse when `Diff`/`Bout` are updated.
- `Diff`  output  WIDTH: registered difference, `(A - B - Bin) mod 2^WIDTH`.
- `Bout`  output  1: registered borrow-out; 1 iff `A < B + Bin` (unsigned).
- `Ovf`  output  1: signed overflow. Present only when `SUB_OVF_EN` is defined.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE → SHIFT when `start`=1 at a clock edge.
  - On that edge: capture `A`, `B`, `Bin` into internal shift registers.
  - Load the running borrow with `Bin`; clear the bit counter to 0.
- SHIFT: each cycle processes bit i = counter.
  - `d_i = a_i ^ b_i ^ br`
  - `br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)`
  - `d_i` shifts into an internal result register from the MSB end.
  - The counter increments; its width is `$clog2(WIDTH+1)`.
- SHIFT → DONE on the edge that processes bit WIDTH-1.
  - On the same edge, load `Diff` from the completed result and `Bout` from the final borrow.
- DONE → IDLE unconditionally on the next edge.
- `start` is ignored in SHIFT and DONE. It is not queued, and operands are not re-sampled.
- Outputs are decoded from registered state, never combinationally from inputs:
  - `busy` = (state == SHIFT)
  - `done` = (state == DONE)
- `Diff`/`Bout` change only on the SHIFT→DONE edge. Otherwise they hold their previous values.
- Reset (`rst_n`=0 at an edge, any state, including mid-SHIFT):
  - State = IDLE; counter and internal registers = 0.
  - `busy`=0, `done`=0, `Diff`=0, `Bout`=0, `Ovf`=0.
  - Any in-flight operation is discarded.
- Simultaneous `rst_n`=0 and `start`=1: reset wins; the start is not accepted.

## Timing
- Accepting edge = edge k. Bits are processed on edges k+1 … k+WIDTH.
- `busy` is high from after edge k until edge k+WIDTH.
- `done` is high for exactly the one cycle between edges k+WIDTH and k+WIDTH+1.
- `Diff`/`Bout` are valid from edge k+WIDTH onward.
- Latency is WIDTH+1 edges from acceptance to the end of `done`. With WIDTH=3 that is 4 edges.
- Back-to-back: `start` held high through DONE is accepted on edge k+WIDTH+2, the first IDLE edge.
- Throughput is one operation per WIDTH+2 cycles.

## Configuration
- `SUB_OVF_EN` defined:
  - Adds the `Ovf` output port and its register.
  - `Ovf` = borrow into the MSB XOR `Bout`.
  - It is loaded together with `Diff` and reset to 0.
- `SUB_OVF_EN` not defined:
  - No `Ovf` port and no overflow logic.
  - All other behaviour is identical.

## Test plan
- Reset, then `A`=5, `B`=2, `Bin`=0, `start` pulse → `busy` high for 3 cycles, then `done` for 1 cycle; `Diff`=3'b011, `Bout`=0.
- `A`=2, `B`=3, `Bin`=0 → `Diff`=3'b111, `Bout`=1. Then `A`=5, `B`=7, `Bin`=1 → `Diff`=3'b101, `Bout`=1.
- `A`=0, `B`=0, `Bin`=1 → `Diff`=3'b111, `Bout`=1. `A`=7, `B`=0, `Bin`=0 → `Diff`=3'b111, `Bout`=0.
- Start `A`=6, `B`=1; pulse `start` with `A`=0, `B`=7 during SHIFT → second request ignored; `Diff`=3'b101, `Bout`=0; exactly one `done`.
- Start an operation, then assert `rst_n`=0 on edge k+2 → all outputs 0 and state IDLE after that edge; no `done` appears afterwards.
- With `SUB_OVF_EN`: `A`=3'b011, `B`=3'b100, `Bin`=0 → `Diff`=3'b111, `Bout`=1, `Ovf`=1. `A`=3'b010, `B`=3'b001 → `Ovf`=0.

Source files
------------

// File: rtl/sub_serial.sv
// sub_serial: bit-serial subtractor, Diff = A - B - Bin, LSB first, start/busy/done handshake.
// Latency: WIDTH+1 edges from the accepting edge to the end of the done pulse; one op per WIDTH+2 cycles.
// Backpressure: none; start is sampled only in IDLE and ignored (not queued) otherwise. Optional Ovf via SUB_OVF_EN.
module sub_serial #(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Diff,
`ifdef SUB_OVF_EN
    output logic             Ovf,
`endif
    output logic             Bout
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CW-1:0]    r_cnt;
    logic             r_br;
    logic [WIDTH-1:0] r_diff;
    logic             r_bout;

    logic             w_accept;
    logic             w_last;
    logic             w_a_bit;
    logic             w_b_bit;
    logic             w_d_bit;
    logic             w_br_nxt;
    logic [WIDTH-1:0] w_res_nxt;

    // Current operand bits always sit at the LSB of the shift registers.
    assign w_a_bit   = r_a[0];
    assign w_b_bit   = r_b[0];
    assign w_d_bit   = w_a_bit ^ w_b_bit ^ r_br;
    assign w_br_nxt  = (~w_a_bit & w_b_bit) | (~(w_a_bit ^ w_b_bit) & r_br);
    // Difference bits enter from the MSB end so the LSB lands at bit 0 after WIDTH shifts.
    assign w_res_nxt = {w_d_bit, r_res[WIDTH-1:1]};

    assign w_accept  = (r_state == IDLE) && start;
    assign w_last    = (r_state == SHIFT) && (r_cnt == LAST_BIT);

    // State register; reset wins over a simultaneous start.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == LAST_BIT) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand capture and per-bit shift datapath.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a   <= '0;
            r_b   <= '0;
            r_res <= '0;
            r_cnt <= '0;
            r_br  <= 1'b0;
        end else if (w_accept) begin
            r_a   <= A;
            r_b   <= B;
            r_res <= '0;
            r_cnt <= '0;
            r_br  <= Bin;
        end else if (r_state == SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_res <= w_res_nxt;
            r_cnt <= r_cnt + 1'b1;
            r_br  <= w_br_nxt;
        end
    end

    // Result registers load only on the edge that processes the MSB, then hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_diff <= '0;
            r_bout <= 1'b0;
        end else if (w_last) begin
            r_diff <= w_res_nxt;
            r_bout <= w_br_nxt;
        end
    end

`ifdef SUB_OVF_EN
    logic r_ovf;

    // Signed overflow: borrow into the MSB differs from the borrow out of it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_last) begin
            r_ovf <= r_br ^ w_br_nxt;
        end
    end

    assign Ovf = r_ovf;
`endif

    assign busy = (r_state == SHIFT);
    assign done = (r_state == DONE);
    assign Diff = r_diff;
    assign Bout = r_bout;

endmodule

// File: tb/tb_sub_serial.sv
// tb_sub_serial: directed self-checking bench for sub_serial with WIDTH=3.
// Inputs are driven and outputs sampled on the falling edge, away from the active rising edge.
// Expected values are hand-computed constants.
module tb_sub_serial;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         bout;
`ifdef SUB_OVF_EN
    logic         ovf;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sub_serial #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .A     (a),
        .B     (b),
        .Bin   (bin),
        .busy  (busy),
        .done  (done),
        .Diff  (diff),
`ifdef SUB_OVF_EN
        .Ovf   (ovf),
`endif
        .Bout  (bout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full operation: pulse start, check busy for W cycles, then done and results, then idle.
    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tbin, input logic [W-1:0] ed, input logic eb, input logic eo);
        @(negedge clk);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < W; i++) begin
            chk({tag, ".busy"}, {31'd0, busy}, 32'd1);
            if (i < W - 1) @(negedge clk);
        end
        @(negedge clk);
        chk({tag, ".done"}, {31'd0, done}, 32'd1);
        chk({tag, ".diff"}, {29'd0, diff}, {29'd0, ed});
        chk({tag, ".bout"}, {31'd0, bout}, {31'd0, eb});
`ifdef SUB_OVF_EN
        chk({tag, ".ovf"}, {31'd0, ovf}, {31'd0, eo});
`else
        if (eo === 1'bx) $display("note: unexpected x in expected ovf for %s", tag);
`endif
        @(negedge clk);
        chk({tag, ".idle_done"}, {31'd0, done}, 32'd0);
        chk({tag, ".idle_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int ndone;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.done", {31'd0, done}, 32'd0);
        chk("rst.diff", {29'd0, diff}, 32'd0);
        chk("rst.bout", {31'd0, bout}, 32'd0);
        rst_n = 1'b1;

        run_op("op5m2",   3'd5, 3'd2, 1'b0, 3'b011, 1'b0, 1'b1);
        run_op("op2m3",   3'd2, 3'd3, 1'b0, 3'b111, 1'b1, 1'b0);
        run_op("op5m7b",  3'd5, 3'd7, 1'b1, 3'b101, 1'b1, 1'b0);
        run_op("op0m0b",  3'd0, 3'd0, 1'b1, 3'b111, 1'b1, 1'b0);
        run_op("op7m0",   3'd7, 3'd0, 1'b0, 3'b111, 1'b0, 1'b0);
        run_op("op3m4",   3'd3, 3'd4, 1'b0, 3'b111, 1'b1, 1'b1);
        run_op("op2m1",   3'd2, 3'd1, 1'b0, 3'b001, 1'b0, 1'b0);

        // start during SHIFT is ignored; exactly one done.
        @(negedge clk);
        a = 3'd6; b = 3'd1; bin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 3'd0; b = 3'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        chk("ign.ndone", ndone, 32'd1);
        chk("ign.diff", {29'd0, diff}, {29'd0, 3'b101});
        chk("ign.bout", {31'd0, bout}, 32'd0);

        // Back-to-back: start held through DONE is accepted on the first IDLE edge.
        a = 3'd7; b = 3'd0; bin = 1'b0; start = 1'b1;
        @(negedge clk);                       // after edge k
        a = 3'd0; b = 3'd0; bin = 1'b1;
        repeat (3) @(negedge clk);            // after edge k+3
        chk("b2b.done1", {31'd0, done}, 32'd1);
        chk("b2b.diff1", {29'd0, diff}, {29'd0, 3'b111});
        chk("b2b.bout1", {31'd0, bout}, 32'd0);
        @(negedge clk);                       // after edge k+4: IDLE
        chk("b2b.idle", {31'd0, busy}, 32'd0);
        @(negedge clk);                       // after edge k+5: accepted
        chk("b2b.busy2", {31'd0, busy}, 32'd1);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("b2b.done2", {31'd0, done}, 32'd1);
        chk("b2b.bout2", {31'd0, bout}, 32'd1);
        @(negedge clk);

        // Reset on edge k+2 aborts the operation; no done afterwards.
        a = 3'd5; b = 3'd2; bin = 1'b0; start = 1'b1;
        @(negedge clk);                       // after edge k
        start = 1'b0;
        @(negedge clk);                       // after edge k+1
        rst_n = 1'b0;
        @(negedge clk);                       // after edge k+2
        chk("mrst.busy", {31'd0, busy}, 32'd0);
        chk("mrst.done", {31'd0, done}, 32'd0);
        chk("mrst.diff", {29'd0, diff}, 32'd0);
        chk("mrst.bout", {31'd0, bout}, 32'd0);
`ifdef SUB_OVF_EN
        chk("mrst.ovf", {31'd0, ovf}, 32'd0);
`endif
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("mrst.quiet", ndone, 32'd0);

        // Reset and start together: start is not accepted.
        rst_n = 1'b0; start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("rststart.busy", {31'd0, busy}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
